// File: rtl/joy_db15_pkg.sv
// rtl/joy_db15_pkg.sv - shared types and constants for the DB15 joystick link
package joy_db15_pkg;

  // Responder frame state
  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SHIFT,
    DONE
  } state_t;

  localparam int BITS_PER_PLAYER_DEF = 12;
  localparam int FRAME_BITS          = 2 * BITS_PER_PLAYER_DEF;

  // Bit positions within one player's word, shared with the receiver
  localparam int BIT_R  = 0;
  localparam int BIT_L  = 1;
  localparam int BIT_D  = 2;
  localparam int BIT_U  = 3;
  localparam int BIT_A  = 4;
  localparam int BIT_B  = 5;
  localparam int BIT_C  = 6;
  localparam int BIT_DB = 7;
  localparam int BIT_E  = 8;
  localparam int BIT_F  = 9;
  localparam int BIT_S  = 10;
  localparam int BIT_LS = 11;

endpackage

// File: rtl/joy_db15_if.sv
// rtl/joy_db15_if.sv - DB15 serial link pins (JOY_CLK, JOY_LOAD, JOY_DATA)
interface joy_db15_if;
  logic joy_clk_in;
  logic joy_load_in;
  logic joy_data_out;

  // master = the host/receiver that clocks the chain
  modport master (output joy_clk_in, output joy_load_in, input joy_data_out);
  // slave = the shift-register chain emulated here
  modport slave  (input joy_clk_in, input joy_load_in, output joy_data_out);
endinterface

// File: rtl/joy_db15_sync_edge.sv
// rtl/joy_db15_sync_edge.sv - multi-flop synchroniser with rising/falling edge detect
module sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic async_in,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  // Resynchronise the pin; everything resets to 1 so an idle-high line
  // never produces a spurious edge when reset is released.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '1;
      prev_q <= 1'b1;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], async_in};
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign level = sync_q[STAGES-1];
  assign rise  = level & ~prev_q;
  assign fall  = ~level & prev_q;

endmodule

// File: rtl/joy_db15_tx.sv
// rtl/joy_db15_tx.sv - DB15 joystick responder: parallel load, serial shift-out
module joy_db15_tx
  import joy_db15_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int BITS_PER_PLAYER = BITS_PER_PLAYER_DEF
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [BITS_PER_PLAYER-1:0] joystick1,
  input  logic [BITS_PER_PLAYER-1:0] joystick2,
  joy_db15_if.slave                  link,
  output logic                       frame_strobe,
  output logic [4:0]                 bit_count
);

  localparam int         FRAME_LEN = 2 * BITS_PER_PLAYER;
  localparam logic [4:0] LAST_BIT  = 5'(FRAME_LEN - 1);

  logic clk_lvl, clk_rise, clk_fall;
  logic load_lvl, load_rise, load_fall;

  sync_edge #(.STAGES(SYNC_STAGES)) u_clk_sync (
    .clk      (clk),
    .reset_n  (reset_n),
    .async_in (link.joy_clk_in),
    .level    (clk_lvl),
    .rise     (clk_rise),
    .fall     (clk_fall)
  );

  sync_edge #(.STAGES(SYNC_STAGES)) u_load_sync (
    .clk      (clk),
    .reset_n  (reset_n),
    .async_in (link.joy_load_in),
    .level    (load_lvl),
    .rise     (load_rise),
    .fall     (load_fall)
  );

  // Only the clock rise and the load level/rise matter to this chain
  logic unused_edges;
  assign unused_edges = &{1'b0, clk_lvl, clk_fall, load_fall};

  state_t               state_q, state_d;
  logic [FRAME_LEN-1:0] sreg_q, sreg_d;
  logic [4:0]           cnt_q, cnt_d;
  logic                 strobe_q, strobe_d;

  // Frame state and datapath registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      sreg_q   <= '1;
      cnt_q    <= '0;
      strobe_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      sreg_q   <= sreg_d;
      cnt_q    <= cnt_d;
      strobe_q <= strobe_d;
    end
  end

  // Next state: load level dominates; the register holds wire (inverted)
  // values so its LSB drives JOY_DATA directly and shifting fills with idle 1s.
  always_comb begin
    state_d  = state_q;
    sreg_d   = sreg_q;
    cnt_d    = cnt_q;
    strobe_d = 1'b0;
    if (!load_lvl) begin
      state_d = LOAD;
      sreg_d  = ~{joystick2, joystick1};
      cnt_d   = '0;
    end else begin
      case (state_q)
        LOAD: begin
          if (load_rise) state_d = SHIFT;
        end
        SHIFT: begin
          if (clk_rise) begin
            sreg_d = {1'b1, sreg_q[FRAME_LEN-1:1]};
            cnt_d  = cnt_q + 5'd1;
            if (cnt_q == LAST_BIT) begin
              state_d  = DONE;
              strobe_d = 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign link.joy_data_out = sreg_q[0];
  assign frame_strobe      = strobe_q;
  assign bit_count         = cnt_q;

endmodule

// File: tb/tb_joy_db15_tx.sv
// tb/tb_joy_db15_tx.sv - scoreboard bench for the DB15 joystick responder
module tb_joy_db15_tx;
  import joy_db15_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [11:0] j1 = '0;
  logic [11:0] j2 = '0;
  logic        frame_strobe;
  logic [4:0]  bit_count;

  joy_db15_if link ();

  always #5 clk = ~clk;

  joy_db15_tx #(.SYNC_STAGES(2), .BITS_PER_PLAYER(12)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .joystick1    (j1),
    .joystick2    (j2),
    .link         (link.slave),
    .frame_strobe (frame_strobe),
    .bit_count    (bit_count)
  );

  int errors = 0;
  int checks = 0;
  int edges = 0;
  int strobes = 0;
  int strobe_edge = -1;
  int base;
  bit exp_q[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, want %0h", tag, got, exp);
    end
  endtask

  // Count strobes and remember which JOY_CLK edge they followed
  always @(negedge clk) begin
    if (frame_strobe === 1'b1) begin
      strobes++;
      strobe_edge = edges;
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_frame(input logic [11:0] a, input logic [11:0] b);
    logic [23:0] w;
    w = ~{b, a};
    exp_q.delete();
    for (int i = 0; i < FRAME_BITS; i++) exp_q.push_back(w[i]);
  endtask

  task automatic do_load(input logic [11:0] a, input logic [11:0] b);
    logic [11:0] ja;
    j1 = a;
    j2 = b;
    push_frame(a, b);
    edges = 0;
    link.joy_load_in = 1'b0;
    cycles(8);
    ja = ~a;
    check_eq("load_data", link.joy_data_out, ja[0]);
    check_eq("load_count", bit_count, 0);
    link.joy_load_in = 1'b1;
    cycles(8);
  endtask

  task automatic clk_pulse();
    link.joy_clk_in = 1'b1;
    edges++;
    cycles(8);
    link.joy_clk_in = 1'b0;
    cycles(8);
  endtask

  task automatic run_clocks(input int n);
    bit e;
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 1'b1;
    check_eq("bit0", link.joy_data_out, e);
    for (int k = 1; k <= n; k++) begin
      clk_pulse();
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 1'b1;
      check_eq($sformatf("bit%0d", k), link.joy_data_out, e);
      check_eq($sformatf("count%0d", k), bit_count, (k < FRAME_BITS) ? k : FRAME_BITS);
    end
  endtask

  initial begin
    link.joy_clk_in  = 1'b0;
    link.joy_load_in = 1'b1;
    cycles(3);
    check_eq("rst_data", link.joy_data_out, 1);
    check_eq("rst_count", bit_count, 0);
    check_eq("rst_strobe", frame_strobe, 0);
    reset_n = 1'b1;
    cycles(2);

    // Idle: JOY_CLK toggles without a load for ~1000 cycles
    edges = 0;
    for (int i = 0; i < 63; i++) begin
      clk_pulse();
      check_eq("idle_data", link.joy_data_out, 1);
      check_eq("idle_count", bit_count, 0);
    end
    check_eq("idle_strobes", strobes, 0);

    // Reference frame
    base = strobes;
    do_load(12'h015, 12'h800);
    run_clocks(24);
    check_eq("frame_strobes", strobes - base, 1);
    check_eq("frame_strobe_edge", strobe_edge, 24);

    // Overrun past the end of the frame
    base = strobes;
    do_load(12'($urandom), 12'($urandom));
    run_clocks(30);
    check_eq("ovr_strobes", strobes - base, 1);
    check_eq("ovr_strobe_edge", strobe_edge, 24);

    // Abort after 10 clocks by reloading
    base = strobes;
    do_load(12'h0A5, 12'h35A);
    run_clocks(10);
    check_eq("abort_strobes", strobes - base, 0);
    do_load(12'hFFF, 12'h123);
    check_eq("abort_count", bit_count, 0);
    run_clocks(24);
    check_eq("abort_next_strobes", strobes - base, 1);

    // Load dominance: clock edges while load is low are ignored, and the
    // parallel inputs keep being captured
    base = strobes;
    j1 = 12'h001;
    j2 = 12'hABC;
    edges = 0;
    link.joy_load_in = 1'b0;
    cycles(8);
    for (int i = 0; i < 3; i++) begin
      clk_pulse();
      check_eq("dom_data", link.joy_data_out, 0);
      check_eq("dom_count", bit_count, 0);
    end
    j1 = 12'h7F0;
    clk_pulse();
    check_eq("dom_follow", link.joy_data_out, 1);
    check_eq("dom_strobes", strobes - base, 0);
    push_frame(j1, j2);
    edges = 0;
    link.joy_load_in = 1'b1;
    cycles(8);
    run_clocks(24);
    check_eq("dom_frame_strobes", strobes - base, 1);

    // Async reset mid-frame at bit 7
    base = strobes;
    do_load(12'h3C3, 12'h0F0);
    run_clocks(7);
    #2;
    reset_n = 1'b0;
    #1;
    check_eq("mrst_data", link.joy_data_out, 1);
    check_eq("mrst_count", bit_count, 0);
    check_eq("mrst_strobe", frame_strobe, 0);
    cycles(2);
    reset_n = 1'b1;
    cycles(2);
    clk_pulse();
    clk_pulse();
    check_eq("post_rst_data", link.joy_data_out, 1);
    check_eq("post_rst_count", bit_count, 0);
    check_eq("mrst_strobes", strobes - base, 0);
    do_load(12'h5A5, 12'hA5A);
    run_clocks(24);
    check_eq("post_rst_strobes", strobes - base, 1);
    check_eq("post_rst_edge", strobe_edge, 24);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
